// File: rtl/butterfly_pipe.sv
// butterfly_pipe: two-stage valid/ready radix-2 combiner producing A+P and A-P per component.
// Optional build macro BFLY_SCALE_EN: halve each result (floor) at HALF_SIZE+1 bits; ovf then never sets.
module butterfly_pipe #(
  parameter int unsigned CPX_SIZE  = 74,
  parameter int unsigned HALF_SIZE = 37,
  parameter int unsigned PAIRS     = 512,
  parameter int unsigned CNT_W     = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CPX_SIZE-1:0] in_top,
  input  logic [CPX_SIZE-1:0] in_prod,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CPX_SIZE-1:0] out_sum,
  output logic [CPX_SIZE-1:0] out_diff,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                ovf
);

  localparam int unsigned EXT_W = HALF_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);

  // Elaboration-time guards on the parameter set.
  if (CPX_SIZE != 2 * HALF_SIZE) begin : g_bad_cpx
    $error("butterfly_pipe: CPX_SIZE must equal 2*HALF_SIZE");
  end
  if ((64'd1 << CNT_W) < 64'(PAIRS)) begin : g_bad_cnt
    $error("butterfly_pipe: CNT_W too narrow for PAIRS");
  end

  logic                s1_valid;
  logic [CPX_SIZE-1:0] s1_top;
  logic [CPX_SIZE-1:0] s1_prod;
  logic [CNT_W-1:0]    cnt;

  logic s2_load_c;
  logic s1_load_c;
  logic out_fire_c;

  // Handshake: each stage refills as soon as its occupant moves on.
  assign s2_load_c  = !out_valid || out_ready;
  assign s1_load_c  = !s1_valid || s2_load_c;
  assign out_fire_c = out_valid && out_ready;
  assign in_ready   = s1_load_c;
  assign out_last   = out_valid && (cnt == CNT_LAST);

  logic [HALF_SIZE-1:0] a_re_c;
  logic [HALF_SIZE-1:0] a_im_c;
  logic [HALF_SIZE-1:0] p_re_c;
  logic [HALF_SIZE-1:0] p_im_c;

  assign a_re_c = s1_top[CPX_SIZE-1:HALF_SIZE];
  assign a_im_c = s1_top[HALF_SIZE-1:0];
  assign p_re_c = s1_prod[CPX_SIZE-1:HALF_SIZE];
  assign p_im_c = s1_prod[HALF_SIZE-1:0];

  logic [HALF_SIZE-1:0] sum_re_c;
  logic [HALF_SIZE-1:0] sum_im_c;
  logic [HALF_SIZE-1:0] diff_re_c;
  logic [HALF_SIZE-1:0] diff_im_c;
  logic                 ovf_c;

`ifdef BFLY_SCALE_EN
  logic [EXT_W-1:0] sum_re_x;
  logic [EXT_W-1:0] sum_im_x;
  logic [EXT_W-1:0] diff_re_x;
  logic [EXT_W-1:0] diff_im_x;

  // One guard bit absorbs the carry; dropping the LSB is an arithmetic shift (floor).
  always_comb begin
    sum_re_x  = {a_re_c[HALF_SIZE-1], a_re_c} + {p_re_c[HALF_SIZE-1], p_re_c};
    sum_im_x  = {a_im_c[HALF_SIZE-1], a_im_c} + {p_im_c[HALF_SIZE-1], p_im_c};
    diff_re_x = {a_re_c[HALF_SIZE-1], a_re_c} - {p_re_c[HALF_SIZE-1], p_re_c};
    diff_im_x = {a_im_c[HALF_SIZE-1], a_im_c} - {p_im_c[HALF_SIZE-1], p_im_c};
    sum_re_c  = HALF_SIZE'(sum_re_x >> 1);
    sum_im_c  = HALF_SIZE'(sum_im_x >> 1);
    diff_re_c = HALF_SIZE'(diff_re_x >> 1);
    diff_im_c = HALF_SIZE'(diff_im_x >> 1);
  end

  assign ovf_c = 1'b0;
`else
  logic ovf_sum_re_c;
  logic ovf_sum_im_c;
  logic ovf_diff_re_c;
  logic ovf_diff_im_c;

  // Wrap arithmetic; overflow is read from operand/result sign bits.
  always_comb begin
    sum_re_c  = a_re_c + p_re_c;
    sum_im_c  = a_im_c + p_im_c;
    diff_re_c = a_re_c - p_re_c;
    diff_im_c = a_im_c - p_im_c;

    ovf_sum_re_c  = (a_re_c[HALF_SIZE-1] == p_re_c[HALF_SIZE-1]) &&
                    (sum_re_c[HALF_SIZE-1] != a_re_c[HALF_SIZE-1]);
    ovf_sum_im_c  = (a_im_c[HALF_SIZE-1] == p_im_c[HALF_SIZE-1]) &&
                    (sum_im_c[HALF_SIZE-1] != a_im_c[HALF_SIZE-1]);
    ovf_diff_re_c = (a_re_c[HALF_SIZE-1] != p_re_c[HALF_SIZE-1]) &&
                    (diff_re_c[HALF_SIZE-1] != a_re_c[HALF_SIZE-1]);
    ovf_diff_im_c = (a_im_c[HALF_SIZE-1] != p_im_c[HALF_SIZE-1]) &&
                    (diff_im_c[HALF_SIZE-1] != a_im_c[HALF_SIZE-1]);
  end

  assign ovf_c = ovf_sum_re_c || ovf_sum_im_c || ovf_diff_re_c || ovf_diff_im_c;
`endif

  // Pipeline registers, sticky overflow and pass counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_top    <= '0;
      s1_prod   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_diff  <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
    end else begin
      if (s1_load_c) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_top  <= in_top;
          s1_prod <= in_prod;
        end
      end

      if (s2_load_c) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sum  <= {sum_re_c, sum_im_c};
          out_diff <= {diff_re_c, diff_im_c};
          ovf      <= ovf || ovf_c;
        end
      end

      if (out_fire_c) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Pipelined radix-2 butterfly combiner that sits directly downstream of the complex multiplier in the butterfly_sum datapath. It receives the top operand A and the twiddle product W·B, already formed by the multiplier, and produces A+W·B and A−W·B. Both paths are registered behind a two-stage valid/ready pipeline. A pair counter marks the last butterfly of each FFT stage pass so the downstream memory writer can close the pass.

## Interface
Parameters:
- CPX_SIZE, 74, packed complex width, {real, imag}.
- HALF_SIZE, 37, width of each real/imag component, two's complement.
- PAIRS, 512, butterflies per stage pass; out_last period.
- CNT_W, 9, pair counter width; must satisfy 2^CNT_W ≥ PAIRS.

Ports (one clock; reset is synchronous and active-low):
- clk, input, 1, sole clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_top, input, CPX_SIZE, operand A.
- in_prod, input, CPX_SIZE, W·B from the complex multiplier.
- in_valid, input, 1, in_top/in_prod valid.
- in_ready, output, 1, block accepts input this cycle.
- out_sum, output, CPX_SIZE, A+W·B.
- out_diff, output, CPX_SIZE, A−W·B.
- out_valid, output, 1, out_sum/out_diff/out_last valid.
- out_ready, input, 1, downstream accepts.
- out_last, output, 1, marks the PAIRS-th output of a pass.
- ovf, output, 1, sticky overflow flag.

## Operation
- Components:
  - Real part = bits [CPX_SIZE-1:HALF_SIZE].
  - Imag part = bits [HALF_SIZE-1:0].
  - Outputs are packed the same way.
- Stage 1 (S1) registers in_top and in_prod on an input accept, which occurs when in_valid && in_ready.
- Stage 2 (S2) computes real and imaginary components independently and registers the results:
  - sum = A + P
  - diff = A − P
- Arithmetic without the macro: HALF_SIZE-bit two's complement, wrap modulo 2^HALF_SIZE.
- Overflow detection, per component:
  - Sum overflows when the operands have equal sign and the result sign differs.
  - Diff overflows when the operand signs differ and the result sign differs from A.
  - Any of the four overflows, on an S1→S2 transfer, sets ovf.
  - ovf clears only on reset.
- Pair counter:
  - Increments on each output accept (out_valid && out_ready).
  - Wraps from PAIRS−1 to 0.
  - out_last = out_valid && (cnt == PAIRS−1).
- Flow control:
  - s2_load = !out_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. This is a combinational path from out_ready; no bubbles at full throughput.
  - Data in a stage is held stable while that stage is stalled.

## Timing
- Latency: input accept in cycle N → out_valid in cycle N+2 if no stall.
- Throughput: one butterfly per cycle while out_ready is held high.
- Simultaneous accept and emit in S1 and S2 are legal in the same cycle; occupancy is preserved.
- Backpressure: with out_ready low, at most 2 entries are held (S1 + S2). in_ready falls once both stages are valid.
- Reset, when rst_n is low at an edge:
  - s1_valid and out_valid = 0.
  - cnt = 0.
  - ovf = 0.
  - out_sum and out_diff = 0.
- Reset mid-operation discards all in-flight entries without emitting them. in_ready is 1 on the first cycle after reset release.
- A stall on the output never corrupts cnt; cnt advances only on accept.

## Configuration
- BFLY_SCALE_EN defined:
  - Each component is computed at HALF_SIZE+1 bits.
  - The result is then arithmetically shifted right by 1, truncating toward −∞, and stored at HALF_SIZE bits.
  - Overflow is impossible; ovf is tied to 0.
- Not defined: unscaled wrap arithmetic with ovf detection as described above. Latency and handshake are identical in both builds.

## Test plan
- Basic: A=(100,−50), P=(30,20), out_ready=1 → 2 cycles later sum=(130,−30), diff=(70,−70), ovf=0.
- Overflow, unscaled build: A.real=2^36−1, P.real=1 → sum.real=−2^36 (wrapped), ovf=1, and ovf stays 1 for all later transactions until rst_n is low.
- Scaling, BFLY_SCALE_EN build: A.real=2^36−1, P.real=1 → sum.real=2^35. A.real=−3, P.real=0 → sum.real=−2. ovf stays 0.
- Backpressure: stream 5 inputs with out_ready=0 → in_ready drops after 2 accepts. Release out_ready → all 5 outputs emerge in order with no loss or duplication.
- Framing: PAIRS=4, stream 10 butterflies with random out_ready stalls → out_last is high on outputs 4 and 8 only, and cnt=2 at the end.
- Reset mid-stream: assert rst_n low with both stages full → next cycle out_valid=0, cnt=0, in_ready=1. The next input emerges as the pass's first output, with out_last low.
